// File: rtl/prf_wb_pkg.sv
// Shared types and helpers for the register-file writeback arbiter:
// address width, byte-enable to bit-mask mapping and the staged-write record.
package prf_wb_pkg;

  localparam int          ADDR_MAX_W = 16;
  localparam logic [31:0] BWC_NONE   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic                  v;
    logic [ADDR_MAX_W-1:0] addr;
    logic [31:0]           data;
    logic [3:0]            be;
  } stage_t;

  function automatic int aw_of(input int depth);
    return $clog2(depth);
  endfunction

  // Active-high byte enables to an active-low per-bit write mask.
  function automatic logic [31:0] be_to_bwc(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      m[8*k +: 8] = {8{~be[k]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/prf_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from r_ptr,
// r_ptr moves to the slot after the winner whenever a grant is taken.
module prf_rr_arbiter
  import prf_wb_pkg::*;
#(
  parameter  int NUM_REQ = 3,
  localparam int IW      = aw_of(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_grant_idx
);

  logic [IW-1:0]      r_ptr;
  logic               w_found;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_idx;

  function automatic int wrap(input int s);
    return (s >= NUM_REQ) ? (s - NUM_REQ) : s;
  endfunction

  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && i_req[i] && (i == wrap(int'(r_ptr) + k))) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_idx      = IW'(i);
        end else begin
          w_found = w_found;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (i_adv && w_found) begin
      r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : (w_idx + IW'(1));
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;

endmodule

// File: rtl/prf32_wb_arbiter.sv
// Writeback arbiter: picks one requester per cycle, stages it for one cycle and
// drives the register file's active-low write port plus a forwarding view.
module prf32_wb_arbiter
  import prf_wb_pkg::*;
#(
  parameter  int NUM_REQ    = 3,
  parameter  int WORD_COUNT = 32,
  parameter  bit ZERO_REG   = 1'b1,
  localparam int AW         = aw_of(WORD_COUNT),
  localparam int IW         = aw_of(NUM_REQ)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_REQ-1:0]    REQ_VALID,
  output logic [NUM_REQ-1:0]    REQ_READY,
  input  logic [NUM_REQ*AW-1:0] REQ_ADDR,
  input  logic [NUM_REQ*32-1:0] REQ_DATA,
  input  logic [NUM_REQ*4-1:0]  REQ_BE,
  output logic                  WEC,
  output logic [31:0]           BWC,
  output logic [31:0]           DC,
  output logic [AW-1:0]         AC,
  output logic                  FWD_VALID,
  output logic [AW-1:0]         FWD_ADDR,
  output logic [31:0]           FWD_DATA,
  output logic [3:0]            FWD_BE
);

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_xfer;
  logic               w_keep;
  logic [AW-1:0]      w_addr;
  logic [31:0]        w_data;
  logic [3:0]         w_be;

  stage_t             r_stage;
  logic               r_wec;
  logic [31:0]        r_bwc;
  logic [AW-1:0]      r_ac;
  logic [31:0]        r_dc;

  assign w_req = REQ_VALID & {NUM_REQ{~RESET}};

  prf_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk       (CLK),
    .i_rst       (RESET),
    .i_req       (w_req),
    .i_adv       (~RESET),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  always_comb begin
    w_addr = '0;
    w_data = 32'h0000_0000;
    w_be   = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == IW'(i)) begin
        w_addr = REQ_ADDR[i*AW +: AW];
        w_data = REQ_DATA[i*32 +: 32];
        w_be   = REQ_BE[i*4 +: 4];
      end else begin
        w_addr = w_addr;
      end
    end
  end

  // Empty byte enables and writes to a hardwired zero register are accepted but never staged.
  assign w_xfer = |w_grant;
  assign w_keep = w_xfer & (w_be != 4'b0000) & ~(ZERO_REG & (w_addr == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stage <= '0;
      r_wec   <= 1'b1;
      r_bwc   <= BWC_NONE;
      r_ac    <= '0;
      r_dc    <= 32'h0000_0000;
    end else begin
      r_stage.v <= w_keep;
      if (w_xfer) begin
        r_stage.addr <= ADDR_MAX_W'(w_addr);
        r_stage.data <= w_data;
        r_stage.be   <= w_be;
      end
      if (w_keep) begin
        r_wec <= 1'b0;
        r_bwc <= be_to_bwc(w_be);
        r_ac  <= w_addr;
        r_dc  <= w_data;
      end else begin
        r_wec <= 1'b1;
        r_bwc <= BWC_NONE;
      end
    end
  end

  // RESET masks the port at once so a write staged before the reset edge never lands.
  assign REQ_READY = w_grant;
  assign WEC       = r_wec | RESET;
  assign BWC       = r_bwc | {32{RESET}};
  assign AC        = r_ac;
  assign DC        = r_dc;
  assign FWD_VALID = r_stage.v & ~RESET;
  assign FWD_ADDR  = AW'(r_stage.addr);
  assign FWD_DATA  = r_stage.data;
  assign FWD_BE    = r_stage.be;

endmodule

// File: tb/tb_prf32_wb_arbiter.sv
// Bench for prf32_wb_arbiter: directed vector table plus randomized traffic checked
// against a behavioural model and a register-file array written from the DUT port.
module tb_prf32_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam bit [31:0] ONES = 32'hFFFF_FFFF;

  logic            CLK;
  logic            RESET;
  logic [N-1:0]    REQ_VALID;
  logic [N-1:0]    REQ_READY;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*32-1:0] REQ_DATA;
  logic [N*4-1:0]  REQ_BE;
  logic            WEC;
  logic [31:0]     BWC;
  logic [31:0]     DC;
  logic [AW-1:0]   AC;
  logic            FWD_VALID;
  logic [AW-1:0]   FWD_ADDR;
  logic [31:0]     FWD_DATA;
  logic [3:0]      FWD_BE;

  prf32_wb_arbiter #(.NUM_REQ(N), .WORD_COUNT(32), .ZERO_REG(1'b1)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA), .REQ_BE(REQ_BE),
    .WEC(WEC), .BWC(BWC), .DC(DC), .AC(AC),
    .FWD_VALID(FWD_VALID), .FWD_ADDR(FWD_ADDR), .FWD_DATA(FWD_DATA), .FWD_BE(FWD_BE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register-file array, written through the DUT's active-low port.
  bit [31:0] arr [32];
  always @(posedge CLK) begin
    if (WEC === 1'b0) arr[AC] <= (arr[AC] & BWC) | (DC & ~BWC);
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: pointer, pending write, port hold values, expected array.
  int        m_ptr;
  bit        m_v;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  bit [3:0]  m_be;
  bit [4:0]  m_ac;
  bit [31:0] m_dc;
  bit        m_clean;
  bit [31:0] ref_mem [32];

  typedef struct {
    bit        rst;
    bit [2:0]  v;
    bit [14:0] a;
    bit [95:0] d;
    bit [11:0] be;
    bit [2:0]  er;
    bit        ew;
    bit [31:0] eb;
  } vec_t;

  vec_t tbl [24];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit [2:0] v, input int who, input bit [4:0] a,
                              input bit [31:0] d, input bit [3:0] be, input bit [2:0] er,
                              input bit ew, input bit [31:0] eb);
    vec_t r;
    r.rst = rst; r.v = v; r.er = er; r.ew = ew; r.eb = eb;
    for (int i = 0; i < N; i++) begin
      r.a[i*5 +: 5]   = 5'(10 + i);
      r.d[i*32 +: 32] = 32'(32'h100 + i);
      r.be[i*4 +: 4]  = 4'hF;
    end
    if (who >= 0) begin
      r.a[who*5 +: 5]   = a;
      r.d[who*32 +: 32] = d;
      r.be[who*4 +: 4]  = be;
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit [2:0] v, input bit [14:0] pa, input bit [95:0] pd,
                      input bit [11:0] pbe, input bit use_t, input bit [2:0] t_rdy,
                      input bit t_wec, input bit [31:0] t_bwc, input int row);
    int        g;
    int        idx;
    bit [2:0]  e_rdy;
    bit        e_wec;
    bit [31:0] e_bwc;
    bit [3:0]  gbe;
    bit [4:0]  ga;
    RESET = rst; REQ_VALID = v; REQ_ADDR = pa; REQ_DATA = pd; REQ_BE = pbe;
    #1;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    e_rdy = 3'b000;
    if (g >= 0) e_rdy[g] = 1'b1;
    e_wec = rst || !m_v;
    e_bwc = ONES;
    if (!e_wec) begin
      for (int k = 0; k < 4; k++) if (m_be[k]) e_bwc[8*k +: 8] = 8'h00;
    end
    chk("ready", {29'd0, REQ_READY}, {29'd0, e_rdy});
    chk("wec", {31'd0, WEC}, {31'd0, e_wec});
    chk("bwc", BWC, e_bwc);
    chk("ac", {27'd0, AC}, {27'd0, m_ac});
    chk("dc", DC, m_dc);
    chk("fwd_valid", {31'd0, FWD_VALID}, {31'd0, !e_wec});
    if (!e_wec || m_clean) begin
      chk("fwd_addr", {27'd0, FWD_ADDR}, {27'd0, m_addr});
      chk("fwd_data", FWD_DATA, m_data);
      chk("fwd_be", {28'd0, FWD_BE}, {28'd0, m_be});
    end
    if (use_t) begin
      chk($sformatf("tbl_ready[%0d]", row), {29'd0, REQ_READY}, {29'd0, t_rdy});
      chk($sformatf("tbl_wec[%0d]", row), {31'd0, WEC}, {31'd0, t_wec});
      chk($sformatf("tbl_bwc[%0d]", row), BWC, t_bwc);
    end
    @(posedge CLK);
    if (rst) begin
      m_ptr = 0; m_v = 1'b0; m_addr = '0; m_data = '0; m_be = '0;
      m_ac = '0; m_dc = '0; m_clean = 1'b1;
    end else begin
      if (m_v) begin
        for (int k = 0; k < 4; k++) if (m_be[k]) ref_mem[m_addr][8*k +: 8] = m_data[8*k +: 8];
      end
      if (g >= 0) begin
        m_ptr   = (g + 1) % N;
        m_clean = 1'b0;
        ga      = pa[g*5 +: 5];
        gbe     = pbe[g*4 +: 4];
        m_v     = (gbe != 4'h0) && (ga != 5'd0);
        m_addr  = ga;
        m_data  = pd[g*32 +: 32];
        m_be    = gbe;
        if (m_v) begin
          m_ac = ga;
          m_dc = m_data;
        end
      end else begin
        m_v = 1'b0;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    bit [2:0]  rv;
    bit [14:0] ra;
    bit [95:0] rd;
    bit [11:0] rb;
    RESET = 1'b1; REQ_VALID = '0; REQ_ADDR = '0; REQ_DATA = '0; REQ_BE = '0;
    m_ptr = 0; m_v = 1'b0; m_addr = '0; m_data = '0; m_be = '0;
    m_ac = '0; m_dc = '0; m_clean = 1'b1;

    // single write, reset, fairness, partial, discards, reset mid-op, same address
    tbl[0]  = mk(1'b0, 3'b010, 1, 5'd5, 32'hDEADBEEF, 4'hF, 3'b010, 1'b1, ONES);
    tbl[1]  = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0);
    tbl[2]  = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b1, ONES);
    tbl[3]  = mk(1'b1, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b1, ONES);
    tbl[4]  = mk(1'b0, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b001, 1'b1, ONES);
    tbl[5]  = mk(1'b0, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b010, 1'b0, 32'h0);
    tbl[6]  = mk(1'b0, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b100, 1'b0, 32'h0);
    tbl[7]  = mk(1'b0, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b001, 1'b0, 32'h0);
    tbl[8]  = mk(1'b0, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b010, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b100, 1'b0, 32'h0);
    tbl[10] = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0);
    tbl[11] = mk(1'b0, 3'b001, 0, 5'd7, 32'h11223344, 4'hF, 3'b001, 1'b1, ONES);
    tbl[12] = mk(1'b0, 3'b010, 1, 5'd7, 32'hAABBCCDD, 4'b0101, 3'b010, 1'b0, 32'h0);
    tbl[13] = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b0, 32'hFF00FF00);
    tbl[14] = mk(1'b0, 3'b100, 2, 5'd0, 32'h55555555, 4'hF, 3'b100, 1'b1, ONES);
    tbl[15] = mk(1'b0, 3'b001, 0, 5'd4, 32'h66666666, 4'h0, 3'b001, 1'b1, ONES);
    tbl[16] = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b1, ONES);
    tbl[17] = mk(1'b0, 3'b100, 2, 5'd9, 32'hCAFEF00D, 4'hF, 3'b100, 1'b1, ONES);
    tbl[18] = mk(1'b1, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b1, ONES);
    tbl[19] = mk(1'b1, 3'b111, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b1, ONES);
    tbl[20] = mk(1'b0, 3'b111, 0, 5'd3, 32'h1, 4'hF, 3'b001, 1'b1, ONES);
    tbl[21] = mk(1'b0, 3'b010, 1, 5'd3, 32'h2, 4'hF, 3'b010, 1'b0, 32'h0);
    tbl[22] = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0);
    tbl[23] = mk(1'b0, 3'b000, -1, 5'd0, 32'h0, 4'h0, 3'b000, 1'b1, ONES);

    @(posedge CLK);
    @(negedge CLK);

    for (int r = 0; r < 24; r++) begin
      step(tbl[r].rst, tbl[r].v, tbl[r].a, tbl[r].d, tbl[r].be, 1'b1,
           tbl[r].er, tbl[r].ew, tbl[r].eb, r);
    end

    chk("reg5_single", arr[5], 32'hDEADBEEF);
    chk("reg7_partial", arr[7], 32'h11BB33DD);
    chk("reg0_zero", arr[0], 32'h0);
    chk("reg4_be0", arr[4], 32'h0);
    chk("reg9_reset_drop", arr[9], 32'h0);
    chk("reg3_order", arr[3], 32'h2);
    for (int i = 0; i < 32; i++) chk($sformatf("mem_dir[%0d]", i), arr[i], ref_mem[i]);

    for (int c = 0; c < 600; c++) begin
      rv = 3'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) begin
        ra[i*5 +: 5]   = 5'($urandom_range(0, 15));
        rd[i*32 +: 32] = $urandom;
        rb[i*4 +: 4]   = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 39) == 0, rv, ra, rd, rb, 1'b0, 3'b000, 1'b0, 32'h0, c);
    end
    step(1'b0, 3'b000, 15'h0, 96'h0, 12'h0, 1'b0, 3'b000, 1'b0, 32'h0, 0);
    step(1'b0, 3'b000, 15'h0, 96'h0, 12'h0, 1'b0, 3'b000, 1'b0, 32'h0, 0);
    for (int i = 0; i < 32; i++) chk($sformatf("mem_rand[%0d]", i), arr[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
